// File: rtl/vga_timing_defs.sv
// SVGA 800x600@60 raster constants shared by the sync generator and the screen renderers.
package vga_timing_defs;

    localparam int H_VISIBLE = 800;
    localparam int H_FRONT   = 40;
    localparam int H_SYNC    = 128;
    localparam int H_BACK    = 88;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 600;
    localparam int V_FRONT   = 1;
    localparam int V_SYNC    = 4;
    localparam int V_BACK    = 23;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic SYNC_POL = 1'b1;

    localparam int WIN_X = 272;
    localparam int WIN_Y = 172;
    localparam int WIN_W = 256;
    localparam int WIN_H = 256;

    localparam int COL_W = 11;
    localparam int ROW_W = 10;
    localparam int ROM_W = 16;

    typedef logic [COL_W-1:0] col_t;
    typedef logic [ROW_W-1:0] row_t;
    typedef logic [ROM_W-1:0] rom_t;

    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with carry-out and sync/visible decodes.
module vga_axis_counter
    import vga_timing_defs::*;
#(
    parameter int VISIBLE = H_VISIBLE,
    parameter int FRONT   = H_FRONT,
    parameter int SYNC    = H_SYNC,
    parameter int BACK    = H_BACK,
    parameter int CNT_W   = COL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             carry,
    output logic             in_sync,
    output logic             in_vis
);

    localparam int TOTAL    = VISIBLE + FRONT + SYNC + BACK;
    localparam int SYNC_BEG = VISIBLE + FRONT;
    localparam int SYNC_END = SYNC_BEG + SYNC;

    logic last;

    assign last  = (cnt == CNT_W'(TOTAL - 1));
    assign carry = en && last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (carry) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign in_sync = (cnt >= CNT_W'(SYNC_BEG)) && (cnt < CNT_W'(SYNC_END));
    assign in_vis  = (cnt < CNT_W'(VISIBLE));

endmodule

// File: rtl/vga_sync_gen_module.sv
// VGA raster source: sync, display enable, coordinates, image-window flag and bitmap ROM address.
module vga_sync_gen_module
    import vga_timing_defs::*;
#(
    parameter int   H_VISIBLE = vga_timing_defs::H_VISIBLE,
    parameter int   H_FRONT   = vga_timing_defs::H_FRONT,
    parameter int   H_SYNC    = vga_timing_defs::H_SYNC,
    parameter int   H_BACK    = vga_timing_defs::H_BACK,
    parameter int   V_VISIBLE = vga_timing_defs::V_VISIBLE,
    parameter int   V_FRONT   = vga_timing_defs::V_FRONT,
    parameter int   V_SYNC    = vga_timing_defs::V_SYNC,
    parameter int   V_BACK    = vga_timing_defs::V_BACK,
    parameter logic SYNC_POL  = vga_timing_defs::SYNC_POL,
    parameter int   WIN_X     = vga_timing_defs::WIN_X,
    parameter int   WIN_Y     = vga_timing_defs::WIN_Y,
    parameter int   WIN_W     = vga_timing_defs::WIN_W,
    parameter int   WIN_H     = vga_timing_defs::WIN_H
) (
    input  logic        CLK_40M,
    input  logic        RSTn,
    output logic        HSYNC_Sig,
    output logic        VSYNC_Sig,
    output logic        Ready_sig,
    output logic [10:0] Column_addr,
    output logic [9:0]  Row_addr,
    output logic        Line_start,
    output logic        Frame_start,
    output logic        In_window,
    output logic [15:0] Rom_addr
);

    if ((WIN_X + WIN_W > H_VISIBLE) || (WIN_Y + WIN_H > V_VISIBLE)) begin : g_win_check
        $error("vga_sync_gen_module: image window extends outside the visible area");
    end

    col_t h_cnt;
    row_t v_cnt;
    logic h_carry;
    logic v_carry_unused;
    logic h_sync, v_sync;
    logic h_vis, v_vis;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .CNT_W   (COL_W)
    ) u_h_axis (
        .clk     (CLK_40M),
        .rst_n   (RSTn),
        .en      (1'b1),
        .cnt     (h_cnt),
        .carry   (h_carry),
        .in_sync (h_sync),
        .in_vis  (h_vis)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .CNT_W   (ROW_W)
    ) u_v_axis (
        .clk     (CLK_40M),
        .rst_n   (RSTn),
        .en      (h_carry),
        .cnt     (v_cnt),
        .carry   (v_carry_unused),
        .in_sync (v_sync),
        .in_vis  (v_vis)
    );

    // p0: combinational decode of the current counter position
    logic win_p0;
    logic ls_p0;
    logic fs_p0;
    rom_t rel_x_p0;
    rom_t rel_y_p0;
    rom_t rom_p0;

    assign win_p0 = (h_cnt >= COL_W'(WIN_X)) && (h_cnt < COL_W'(WIN_X + WIN_W)) &&
                    (v_cnt >= ROW_W'(WIN_Y)) && (v_cnt < ROW_W'(WIN_Y + WIN_H));
    assign ls_p0  = (h_cnt == '0);
    assign fs_p0  = ls_p0 && (v_cnt == '0);

    // Offsets wrap below the window corner, so the address is only taken inside it.
    assign rel_x_p0 = ROM_W'(h_cnt) - ROM_W'(WIN_X);
    assign rel_y_p0 = ROM_W'(v_cnt) - ROM_W'(WIN_Y);
    assign rom_p0   = win_p0 ? (rel_y_p0 * ROM_W'(WIN_W)) + rel_x_p0 : '0;

    // p1: registered outputs, one cycle behind the counters
    logic hsync_p1, vsync_p1, vld_p1, ls_p1, fs_p1, win_p1;
    col_t col_p1;
    row_t row_p1;
    rom_t rom_p1;

    always_ff @(posedge CLK_40M or negedge RSTn) begin
        if (!RSTn) begin
            hsync_p1 <= ~SYNC_POL;
            vsync_p1 <= ~SYNC_POL;
            vld_p1   <= 1'b0;
            ls_p1    <= 1'b0;
            fs_p1    <= 1'b0;
            win_p1   <= 1'b0;
            col_p1   <= '0;
            row_p1   <= '0;
            rom_p1   <= '0;
        end else begin
            hsync_p1 <= sync_level(h_sync, SYNC_POL);
            vsync_p1 <= sync_level(v_sync, SYNC_POL);
            vld_p1   <= h_vis && v_vis;
            ls_p1    <= ls_p0;
            fs_p1    <= fs_p0;
            win_p1   <= win_p0;
            col_p1   <= h_cnt;
            row_p1   <= v_cnt;
            rom_p1   <= rom_p0;
        end
    end

    assign HSYNC_Sig   = hsync_p1;
    assign VSYNC_Sig   = vsync_p1;
    assign Ready_sig   = vld_p1;
    assign Line_start  = ls_p1;
    assign Frame_start = fs_p1;
    assign In_window   = win_p1;
    assign Column_addr = col_p1;
    assign Row_addr    = row_p1;
    assign Rom_addr    = rom_p1;

endmodule

// File: tb/tb_vga_sync_gen_module.sv
// Directed bench: default SVGA timing, a 256x256 window on a shortened raster, and a tiny raster.
module tb_vga_sync_gen_module;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_d, rst_n_w, rst_n_s;

    logic        hs_d, vs_d, rdy_d, ls_d, fs_d, win_d;
    logic [10:0] col_d;
    logic [9:0]  row_d;
    logic [15:0] rom_d;

    logic        hs_w, vs_w, rdy_w, ls_w, fs_w, win_w;
    logic [10:0] col_w;
    logic [9:0]  row_w;
    logic [15:0] rom_w;

    logic        hs_s, vs_s, rdy_s, ls_s, fs_s, win_s;
    logic [10:0] col_s;
    logic [9:0]  row_s;
    logic [15:0] rom_s;

    vga_sync_gen_module dut_d (
        .CLK_40M(clk), .RSTn(rst_n_d), .HSYNC_Sig(hs_d), .VSYNC_Sig(vs_d), .Ready_sig(rdy_d),
        .Column_addr(col_d), .Row_addr(row_d), .Line_start(ls_d), .Frame_start(fs_d),
        .In_window(win_d), .Rom_addr(rom_d)
    );

    vga_sync_gen_module #(
        .H_VISIBLE(260), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(260), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_POL(1'b1), .WIN_X(2), .WIN_Y(2), .WIN_W(256), .WIN_H(256)
    ) dut_w (
        .CLK_40M(clk), .RSTn(rst_n_w), .HSYNC_Sig(hs_w), .VSYNC_Sig(vs_w), .Ready_sig(rdy_w),
        .Column_addr(col_w), .Row_addr(row_w), .Line_start(ls_w), .Frame_start(fs_w),
        .In_window(win_w), .Rom_addr(rom_w)
    );

    vga_sync_gen_module #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_POL(1'b1), .WIN_X(3), .WIN_Y(2), .WIN_W(2), .WIN_H(2)
    ) dut_s (
        .CLK_40M(clk), .RSTn(rst_n_s), .HSYNC_Sig(hs_s), .VSYNC_Sig(vs_s), .Ready_sig(rdy_s),
        .Column_addr(col_s), .Row_addr(row_s), .Line_start(ls_s), .Frame_start(fs_s),
        .In_window(win_s), .Rom_addr(rom_s)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_w(input int col, input int row);
        bit hit = 1'b0;
        for (int i = 0; i < 70000 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (col_w == 11'(col) && row_w == 10'(row)) hit = 1'b1;
        end
        check_val($sformatf("reach_w_%0d_%0d", col, row), 64'(hit), 64'd1);
    endtask

    task automatic check_reset_d(input string pfx);
        check_val({pfx, "_hsync"}, 64'(hs_d), 64'd0);
        check_val({pfx, "_vsync"}, 64'(vs_d), 64'd0);
        check_val({pfx, "_ready"}, 64'(rdy_d), 64'd0);
        check_val({pfx, "_col"}, 64'(col_d), 64'd0);
        check_val({pfx, "_row"}, 64'(row_d), 64'd0);
        check_val({pfx, "_rom"}, 64'(rom_d), 64'd0);
        check_val({pfx, "_ls"}, 64'(ls_d), 64'd0);
        check_val({pfx, "_fs"}, 64'(fs_d), 64'd0);
        check_val({pfx, "_win"}, 64'(win_d), 64'd0);
    endtask

    function automatic logic [63:0] pack_out(input logic hs, input logic vs, input logic rdy,
                                             input logic ls, input logic fs, input logic win,
                                             input logic [10:0] col, input logic [9:0] row,
                                             input logic [15:0] rom);
        return {21'd0, hs, vs, rdy, ls, fs, win, col, row, rom};
    endfunction

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ls_prev, rdy_run, rdy_max, hs_len, hs_min, hs_max, vs_cnt, fs_cnt;
        bit found;
        int p, c, r, e_rom;
        logic e_hs, e_vs, e_rdy, e_ls, e_fs, e_win;

        rst_n_d = 1'b0;
        rst_n_w = 1'b0;
        rst_n_s = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_reset_d("rst");

        // Default timing: three full lines after release
        @(negedge clk);
        rst_n_d = 1'b1;
        ls_prev = 0; rdy_run = 0; rdy_max = 0; hs_len = 0; hs_min = 9999; hs_max = 0;
        vs_cnt = 0; fs_cnt = 0;
        for (int n = 1; n <= 3 * 1056 + 1; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                check_val("first_fs", 64'(fs_d), 64'd1);
                check_val("first_ls", 64'(ls_d), 64'd1);
                check_val("first_col", 64'(col_d), 64'd0);
                check_val("first_row", 64'(row_d), 64'd0);
                check_val("first_ready", 64'(rdy_d), 64'd1);
            end
            if (ls_d) begin
                if (n > 1) begin
                    check_val("ls_period", 64'(n - ls_prev), 64'd1056);
                    check_val("ready_run", 64'(rdy_run), 64'd800);
                    check_val("ready_last_col", 64'(rdy_max), 64'd799);
                    check_val("hs_len", 64'(hs_len), 64'd128);
                    check_val("hs_first_col", 64'(hs_min), 64'd840);
                    check_val("hs_last_col", 64'(hs_max), 64'd967);
                    check_val("ls_row", 64'(row_d), 64'((n - 1) / 1056));
                end
                check_val("ls_col", 64'(col_d), 64'd0);
                ls_prev = n; rdy_run = 0; rdy_max = 0; hs_len = 0; hs_min = 9999; hs_max = 0;
            end
            if (rdy_d) begin
                rdy_run++;
                if (int'(col_d) > rdy_max) rdy_max = int'(col_d);
            end
            if (hs_d) begin
                hs_len++;
                if (int'(col_d) < hs_min) hs_min = int'(col_d);
                if (int'(col_d) > hs_max) hs_max = int'(col_d);
            end
            if (vs_d) vs_cnt++;
            if (fs_d) fs_cnt++;
        end
        check_val("vsync_rows0_2", 64'(vs_cnt), 64'd0);
        check_val("fs_once", 64'(fs_cnt), 64'd1);

        // Mid-frame reset at column 400 of row 3
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(posedge clk);
            #1;
            if (col_d == 11'd400) found = 1'b1;
        end
        check_val("mid_reach", 64'(found), 64'd1);
        check_val("mid_row", 64'(row_d), 64'd3);
        check_val("mid_ready", 64'(rdy_d), 64'd1);
        rst_n_d = 1'b0;
        #1;
        check_reset_d("mid_rst");
        repeat (3) @(posedge clk);
        #1;
        check_val("mid_hold_col", 64'(col_d), 64'd0);
        @(negedge clk);
        rst_n_d = 1'b1;
        @(posedge clk);
        #1;
        check_val("rel_fs", 64'(fs_d), 64'd1);
        check_val("rel_ls", 64'(ls_d), 64'd1);
        check_val("rel_col", 64'(col_d), 64'd0);
        check_val("rel_row", 64'(row_d), 64'd0);
        check_val("rel_ready", 64'(rdy_d), 64'd1);
        @(posedge clk);
        #1;
        check_val("rel_col1", 64'(col_d), 64'd1);
        check_val("rel_fs1", 64'(fs_d), 64'd0);

        // 256x256 window at (2,2) on a 260x260 raster
        @(negedge clk);
        rst_n_w = 1'b1;
        wait_w(1, 2);
        check_val("w_left_out_win", 64'(win_w), 64'd0);
        check_val("w_left_out_rom", 64'(rom_w), 64'd0);
        wait_w(2, 2);
        check_val("w_corner_win", 64'(win_w), 64'd1);
        check_val("w_corner_rom", 64'(rom_w), 64'd0);
        wait_w(257, 2);
        check_val("w_row0_end_rom", 64'(rom_w), 64'd255);
        wait_w(2, 3);
        check_val("w_row1_start_rom", 64'(rom_w), 64'd256);
        wait_w(257, 257);
        check_val("w_last_win", 64'(win_w), 64'd1);
        check_val("w_last_rom", 64'(rom_w), 64'd65535);
        wait_w(258, 257);
        check_val("w_right_out_win", 64'(win_w), 64'd0);
        check_val("w_right_out_rom", 64'(rom_w), 64'd0);
        check_val("w_right_out_ready", 64'(rdy_w), 64'd1);

        // Tiny raster (14x9), three frames against a position model
        @(negedge clk);
        rst_n_s = 1'b1;
        for (int n = 1; n <= 3 * 126; n++) begin
            @(posedge clk);
            #1;
            p = n - 1;
            c = p % 14;
            r = (p / 14) % 9;
            e_hs  = (c >= 10) && (c < 12);
            e_vs  = (r == 7);
            e_rdy = (c < 8) && (r < 6);
            e_win = (c >= 3) && (c < 5) && (r >= 2) && (r < 4);
            e_rom = e_win ? (r - 2) * 2 + (c - 3) : 0;
            e_ls  = (c == 0);
            e_fs  = (c == 0) && (r == 0);
            check_val($sformatf("small_raster_c%0d_r%0d", c, r),
                      pack_out(hs_s, vs_s, rdy_s, ls_s, fs_s, win_s, col_s, row_s, rom_s),
                      pack_out(e_hs, e_vs, e_rdy, e_ls, e_fs, e_win, 11'(c), 10'(r), 16'(e_rom)));
        end

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
